// File: rtl/memread_addr_gen.sv
// Tile address generator: walks rows x cols, feeds an external pipelined multiplier
// with (row, cols), and assembles base + row*cols + col into a backpressured stream.
module memread_addr_gen #(
    parameter int ROW_W   = 16,
    parameter int COL_W   = 8,
    parameter int ADDR_W  = 24,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [COL_W-1:0]  cfg_cols,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic              busy,
    output logic              done,
    output logic              mul_ce,
    output logic [ROW_W-1:0]  mul_din0,
    output logic [COL_W-1:0]  mul_din1,
    input  logic [ADDR_W-1:0] mul_dout,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr_data,
    output logic              addr_last,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t                          state_q, state_d;
    logic [ROW_W-1:0]                row_q, row_d, rows_q, rows_d;
    logic [COL_W-1:0]                col_q, col_d, cols_q, cols_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic                            empty_q, empty_d;
    logic [MUL_LAT-1:0]              sh_v_q, sh_v_d, sh_last_q, sh_last_d;
    logic [MUL_LAT-1:0][COL_W-1:0]   sh_col_q, sh_col_d;
    logic                            addr_valid_q, addr_valid_d, addr_last_q, addr_last_d;
    logic [ADDR_W-1:0]               addr_data_q, addr_data_d;
    logic                            issue, issue_last, col_wrap;

    // A beat transfers on any cycle with addr_valid && addr_ready; once addr_valid is
    // raised, addr_valid/addr_data/addr_last hold until that transfer. The whole
    // pipeline (counters, multiplier, shadow stages, output) moves together on mul_ce.
    assign mul_ce     = !addr_valid_q || addr_ready;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done       = (state_q == S_FIN);
    assign mul_din0   = row_q;
    assign mul_din1   = cols_q;
    assign addr_valid = addr_valid_q;
    assign addr_data  = addr_data_q;
    assign addr_last  = addr_last_q;
    assign dbg_state  = state_q;

    assign col_wrap   = (col_q == cols_q - COL_W'(1));
    assign issue_last = col_wrap && (row_q == rows_q - ROW_W'(1));

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        base_d       = base_q;
        empty_d      = empty_q;
        issue        = 1'b0;
        sh_v_d       = sh_v_q;
        sh_col_d     = sh_col_q;
        sh_last_d    = sh_last_q;
        addr_valid_d = addr_valid_q;
        addr_data_d  = addr_data_q;
        addr_last_d  = addr_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d  = cfg_rows;
                    cols_d  = cfg_cols;
                    base_d  = cfg_base;
                    row_d   = '0;
                    col_d   = '0;
                    empty_d = (cfg_rows == '0) || (cfg_cols == '0);
                    // An empty tile idles one cycle in DRAIN so busy is visibly asserted.
                    state_d = empty_d ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mul_ce) begin
                    issue = 1'b1;
                    if (col_wrap) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (issue_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (empty_q || (addr_valid_q && addr_ready && addr_last_q)) begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (mul_ce) begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                sh_v_d[i]    = sh_v_q[i-1];
                sh_col_d[i]  = sh_col_q[i-1];
                sh_last_d[i] = sh_last_q[i-1];
            end
            sh_v_d[0]    = issue;
            sh_col_d[0]  = col_q;
            sh_last_d[0] = issue && issue_last;
            // Tail of the shadow pipe lines up with the product of the same operands.
            addr_valid_d = sh_v_q[MUL_LAT-1];
            addr_data_d  = base_q + mul_dout + ADDR_W'(sh_col_q[MUL_LAT-1]);
            addr_last_d  = sh_last_q[MUL_LAT-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            base_q       <= '0;
            empty_q      <= 1'b0;
            sh_v_q       <= '0;
            sh_col_q     <= '0;
            sh_last_q    <= '0;
            addr_valid_q <= 1'b0;
            addr_data_q  <= '0;
            addr_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            base_q       <= base_d;
            empty_q      <= empty_d;
            sh_v_q       <= sh_v_d;
            sh_col_q     <= sh_col_d;
            sh_last_q    <= sh_last_d;
            addr_valid_q <= addr_valid_d;
            addr_data_q  <= addr_data_d;
            addr_last_q  <= addr_last_d;
        end
    end

endmodule

// File: tb/tb_memread_addr_gen.sv
// Bench for memread_addr_gen: models the multiplier, predicts the address stream
// arithmetically per tile, and checks every accepted beat plus key timing points.
module tb_memread_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] cfg_rows;
    logic [7:0]  cfg_cols;
    logic [23:0] cfg_base;
    logic        busy, done, mul_ce, addr_valid, addr_last;
    logic [15:0] mul_din0;
    logic [7:0]  mul_din1;
    logic [23:0] mul_dout, addr_data;
    logic        addr_ready = 1'b1;
    logic [1:0]  dbg_state;

    memread_addr_gen dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_base(cfg_base),
        .busy(busy), .done(done), .mul_ce(mul_ce),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .addr_valid(addr_valid), .addr_ready(addr_ready),
        .addr_data(addr_data), .addr_last(addr_last), .dbg_state(dbg_state)
    );

    // clock / reset-free multiplier model (3 ce-gated stages, stale contents at power-up)
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] mp0 = 24'h3c3c3c, mp1 = 24'ha5a5a5, mp2 = 24'h777777;
    always @(posedge clk) begin
        if (mul_ce) begin
            mp0 <= 24'(mul_din0) * 24'(mul_din1);
            mp1 <= mp0;
            mp2 <= mp1;
        end
    end
    assign mul_dout = mp2;

    // scoreboard state
    logic [24:0] exp_q[$];
    logic [23:0] got_q[$];
    int          got_cyc_q[$];
    int checks = 0, failures = 0;
    int acc_total = 0, valid_seen = 0, ce_low = 0, done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [23:0] held_data;
    logic        held_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // expected stream: base + r*cols + c for the first (up to 400) beats of a tile
    task automatic push_model(input int r, input int c, input logic [23:0] b);
        longint n;
        int cap;
        n = longint'(r) * longint'(c);
        cap = (n > 400) ? 400 : int'(n);
        for (int k = 0; k < cap; k++) begin
            longint row_i, col_i;
            logic [24:0] e;
            row_i = k / c;
            col_i = k % c;
            e[23:0] = 24'(longint'(b) + row_i * c + col_i);
            e[24] = (longint'(k) == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // ready driver: always-high, random, or one 5-cycle stall after beat 2 of a tile
    int rand_ready = 0, stall_req = 0, stall_served = 0, stall_left = 0, tile_base_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            addr_ready = 1'b0;
            stall_left--;
        end else if (stall_req != stall_served && acc_total - tile_base_cnt >= 2) begin
            stall_served = stall_req;
            addr_ready = 1'b0;
            stall_left = 4;
        end else if (rand_ready != 0) begin
            addr_ready = ($urandom_range(0, 3) != 0);
        end else begin
            addr_ready = 1'b1;
        end
    end

    // compare process
    always @(negedge clk) begin
        if (!reset) begin
            check("mul_ce_rule", mul_ce, !addr_valid || addr_ready);
            if (prev_stall) begin
                check("hold_valid", addr_valid, 1);
                check("hold_data", addr_data, held_data);
                check("hold_last", addr_last, held_last);
            end
            if (addr_valid) valid_seen++;
            if (addr_valid && addr_ready) begin
                acc_total++;
                got_q.push_back(addr_data);
                got_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected: got 0x%0h expected no beat", addr_data);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    check("addr_data", addr_data, e[23:0]);
                    check("addr_last", addr_last, e[24]);
                end
            end
            if (!mul_ce) ce_low++;
            if (done) done_cnt++;
            prev_stall = addr_valid && !addr_ready;
            held_data  = addr_data;
            held_last  = addr_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // driver tasks
    task automatic start_tile(input int r, input int c, input logic [23:0] b, output int s);
        @(posedge clk);
        #1;
        cfg_rows = 16'(r);
        cfg_cols = 8'(c);
        cfg_base = b;
        start = 1'b1;
        s = cyc;
        push_model(r, c, b);
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_rows = 16'($urandom);
        cfg_cols = 8'($urandom);
        cfg_base = 24'($urandom);
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n;
        n = 0;
        dcyc = -1;
        while (n < budget && dcyc < 0) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                check("busy_at_done", busy, 0);
            end
            n++;
        end
        if (dcyc < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done within %0d cycles, required one", budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, addr_valid, 0);
        check({tag, "_data"}, addr_data, 0);
        check({tag, "_last"}, addr_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_din0"}, mul_din0, 0);
        check({tag, "_din1"}, mul_din1, 0);
        check({tag, "_ce"}, mul_ce, 1);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [23:0] t1_exp[6] = '{24'h100, 24'h101, 24'h102, 24'h103, 24'h104, 24'h105};

    initial begin
        int s, dc, g0, d0, v0, c0;
        reset = 1'b1;
        start = 1'b0;
        cfg_rows = '0;
        cfg_cols = '0;
        cfg_base = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // basic 2x3 tile, with a start pulse while busy that must be ignored
        g0 = got_q.size();
        d0 = done_cnt;
        start_tile(2, 3, 24'h000100, s);
        @(negedge clk);
        check("t1_busy_after_start", busy, 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_rows = 16'd7;
        cfg_cols = 8'd9;
        cfg_base = 24'h555000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, dc);
        check("t1_done_cycle", dc, s + 11);
        repeat (3) @(negedge clk);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_beats", got_q.size() - g0, 6);
        if (got_q.size() - g0 >= 6) begin
            for (int i = 0; i < 6; i++) check("t1_literal", got_q[g0+i], t1_exp[i]);
            check("t1_first_valid_cyc", got_cyc_q[g0], s + 5);
            check("t1_last_valid_cyc", got_cyc_q[g0+5], s + 10);
        end

        // same tile with a 5-cycle stall after the second beat
        g0 = got_q.size();
        d0 = done_cnt;
        c0 = ce_low;
        tile_base_cnt = acc_total;
        stall_req++;
        start_tile(2, 3, 24'h000100, s);
        wait_done(100, dc);
        check("t2_done_cycle", dc, s + 16);
        repeat (3) @(negedge clk);
        check("t2_ce_low_cycles", ce_low - c0, 5);
        check("t2_done_once", done_cnt - d0, 1);
        check("t2_beats", got_q.size() - g0, 6);
        if (got_q.size() - g0 >= 6) begin
            for (int i = 0; i < 6; i++) check("t2_literal", got_q[g0+i], t1_exp[i]);
        end

        // zero-size tiles
        for (int z = 0; z < 2; z++) begin
            v0 = valid_seen;
            d0 = done_cnt;
            start_tile(z == 0 ? 0 : 4, z == 0 ? 5 : 0, 24'h00abcd, s);
            @(negedge clk);
            check("zero_busy_s1", busy, 1);
            check("zero_done_s1", done, 0);
            @(negedge clk);
            check("zero_done_s2", done, 1);
            check("zero_busy_s2", busy, 0);
            @(negedge clk);
            check("zero_done_s3", done, 0);
            check("zero_busy_s3", busy, 0);
            check("zero_no_valid", valid_seen - v0, 0);
            check("zero_done_once", done_cnt - d0, 1);
        end

        // back-to-back random tiles under random backpressure
        rand_ready = 1;
        d0 = done_cnt;
        for (int t = 0; t < 6; t++) begin
            start_tile($urandom_range(1, 4), $urandom_range(1, 6), 24'($urandom), s);
            wait_done(300, dc);
        end
        rand_ready = 0;
        repeat (3) @(negedge clk);
        check("rand_done_count", done_cnt - d0, 6);
        check("rand_exp_empty", exp_q.size(), 0);

        // large tile: address wrap modulo 2^24, then abandoned by reset
        g0 = got_q.size();
        start_tile(16'hFFFF, 8'hFF, 24'hFFFFF0, s);
        repeat (300) @(negedge clk);
        check("big_enough_beats", (got_q.size() - g0) >= 257, 1);
        if (got_q.size() - g0 >= 257) begin
            check("big_first", got_q[g0], 24'hFFFFF0);
            check("big_idx15", got_q[g0+15], 24'hFFFFFF);
            check("big_wrap", got_q[g0+16], 24'h000000);
            check("big_row1_start", got_q[g0+255], 24'h0000EF);
            check("big_row1_next", got_q[g0+256], 24'h0000F0);
        end
        reset_pulse();

        // reset mid-tile, then a small tile must yield only its own addresses
        d0 = done_cnt;
        start_tile(4, 4, 24'h002000, s);
        repeat (8) @(negedge clk);
        reset_pulse();
        g0 = got_q.size();
        start_tile(1, 2, 24'h000010, s);
        wait_done(100, dc);
        check("t6_done_cycle", dc, s + 7);
        repeat (6) @(negedge clk);
        check("t6_beats", got_q.size() - g0, 2);
        if (got_q.size() - g0 >= 2) begin
            check("t6_addr0", got_q[g0], 24'h000010);
            check("t6_addr1", got_q[g0+1], 24'h000011);
        end
        check("t6_done_once", done_cnt - d0, 1);
        check("t6_exp_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
